// File: rtl/uart_alu_top.sv
// ============================================================================
//  Module      : uart_alu_top (with local uart_rx / uart_tx)
//  Description : UART-fronted chunked multi-precision ADD/SUB engine.
//                Optional checksum byte when UART_ALU_CHKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx,
    output logic [7:0] oData,
    output logic       oValid
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] c_full = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

    logic          rSync1, rSync2;
    logic [1:0]    rState;
    logic [CW-1:0] rCnt;
    logic [2:0]    rBit;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rSync1 <= 1'b1; rSync2 <= 1'b1; rState <= R_IDLE;
            rCnt   <= '0;   rBit   <= '0;   oData  <= '0; oValid <= 1'b0;
        end else begin
            rSync1 <= iRx;
            rSync2 <= rSync1;
            oValid <= 1'b0;
            case (rState)
                R_IDLE: begin
                    rCnt <= '0;
                    rBit <= '0;
                    if (!rSync2) rState <= R_START;
                end
                R_START: if (rCnt == c_half) begin
                    rCnt   <= '0;
                    rState <= rSync2 ? R_IDLE : R_DATA;  // glitch rejection
                end else rCnt <= rCnt + 1'b1;
                R_DATA: if (rCnt == c_full) begin
                    rCnt  <= '0;
                    oData <= {rSync2, oData[7:1]};
                    rBit  <= rBit + 1'b1;
                    if (rBit == 3'd7) rState <= R_STOP;
                end else rCnt <= rCnt + 1'b1;
                default: if (rCnt == c_full) begin
                    rCnt   <= '0;
                    oValid <= rSync2;
                    rState <= R_IDLE;
                end else rCnt <= rCnt + 1'b1;
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [7:0] iData,
    output logic       oTx,
    output logic       oBusy,
    output logic       oDone
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] c_full = CW'(CLKS_PER_BIT - 1);

    logic [8:0]    rShift;
    logic [CW-1:0] rCnt;
    logic [3:0]    rBitIdx;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oTx <= 1'b1; oBusy <= 1'b0; oDone <= 1'b0;
            rShift <= '1; rCnt <= '0; rBitIdx <= '0;
        end else begin
            oDone <= 1'b0;
            if (!oBusy) begin
                if (iStart) begin
                    rShift  <= {1'b1, iData};
                    oTx     <= 1'b0;
                    oBusy   <= 1'b1;
                    rCnt    <= '0;
                    rBitIdx <= '0;
                end
            end else if (rCnt == c_full) begin
                rCnt <= '0;
                if (rBitIdx == 4'd9) begin
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                end else begin
                    oTx     <= rShift[0];
                    rShift  <= {1'b1, rShift[8:1]};
                    rBitIdx <= rBitIdx + 1'b1;
                end
            end else rCnt <= rCnt + 1'b1;
        end
    end
endmodule

module uart_alu_top #(
    parameter int OPERAND_WIDTH  = 512,
    parameter int ADDER_WIDTH    = 32,
    parameter int CLK_FREQ       = 125_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iRx,
    output logic oTx,
    output logic oBusy,
    output logic oFrameErr
);
    localparam int NBYTES       = OPERAND_WIDTH / 8;
    localparam int NCHUNK       = OPERAND_WIDTH / ADDER_WIDTH;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
`ifdef UART_ALU_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int BW  = $clog2(NBYTES + 1);
    localparam int CHW = $clog2(NCHUNK + 1);
    localparam int TXW = $clog2(NBYTES + 3);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0]  c_lastByte   = BW'(NBYTES - 1);
    localparam logic [CHW-1:0] c_lastChunk  = CHW'(NCHUNK - 1);
    localparam logic [TOW-1:0] c_timeout    = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [TXW-1:0] c_txLastFull = TXW'(NBYTES + CHK);
    localparam logic [TXW-1:0] c_txLastErr  = TXW'(CHK);

    localparam logic [2:0] S_IDLE = 3'd0, S_RX_OP = 3'd1, S_RX_A = 3'd2, S_RX_B = 3'd3,
                           S_COMPUTE = 3'd4, S_TX = 3'd5, S_TX_WAIT = 3'd6;

    logic [2:0]               rState;
    logic [OPERAND_WIDTH-1:0] rA, rB;
    logic                     rSub, rCarry, rBusy, rFrameErr, rTxStart;
    logic [7:0]               rHead, rChk, rTxData;
    logic [BW-1:0]            rByteCnt;
    logic [CHW-1:0]           rChunk;
    logic [TOW-1:0]           rTout;
    logic [TXW-1:0]           rTxCnt, rTxLast;

    logic [7:0]               wRxData, wTxByte;
    logic                     wRxValid, wTxBusy, wTxDone;
    logic [ADDER_WIDTH-1:0]   wBChunk;
    logic [ADDER_WIDTH:0]     wSum;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .iClk(iClk), .iRst(iRst), .iRx(iRx), .oData(wRxData), .oValid(wRxValid));
    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uTx (
        .iClk(iClk), .iRst(iRst), .iStart(rTxStart), .iData(rTxData),
        .oTx(oTx), .oBusy(wTxBusy), .oDone(wTxDone));

    // Operands rotate right one chunk per cycle; sums enter at the top so the
    // result ends up in rA in natural bit order after the last chunk.
    always_comb begin
        wBChunk = rSub ? ~rB[ADDER_WIDTH-1:0] : rB[ADDER_WIDTH-1:0];
        wSum    = {1'b0, rA[ADDER_WIDTH-1:0]} + {1'b0, wBChunk} + {{ADDER_WIDTH{1'b0}}, rCarry};
        wTxByte = rA[OPERAND_WIDTH-1 -: 8];
        if (rTxCnt == '0)                           wTxByte = rHead;
        else if (CHK != 0 && rTxCnt == rTxLast)     wTxByte = rChk;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rState <= S_IDLE; rA <= '0; rB <= '0; rSub <= 1'b0; rCarry <= 1'b0;
            rBusy <= 1'b0; rFrameErr <= 1'b0; rTxStart <= 1'b0; rHead <= '0;
            rChk <= '0; rTxData <= '0; rByteCnt <= '0; rChunk <= '0; rTout <= '0;
            rTxCnt <= '0; rTxLast <= '0;
        end else begin
            rTxStart  <= 1'b0;
            rFrameErr <= 1'b0;
            case (rState)
                S_IDLE: begin
                    rBusy  <= 1'b0;
                    rState <= S_RX_OP;
                end
                S_RX_OP: if (wRxValid) begin
                    rBusy    <= 1'b1;
                    rByteCnt <= '0;
                    rTout    <= '0;
                    if (wRxData == 8'h01 || wRxData == 8'h02) begin
                        rSub   <= (wRxData == 8'h02);
                        rState <= S_RX_A;
                    end else begin
                        rFrameErr <= 1'b1;
                        rHead     <= 8'hEE;
                        rTxCnt    <= '0;
                        rTxLast   <= c_txLastErr;
                        rChk      <= '0;
                        rState    <= S_TX;
                    end
                end
                S_RX_A, S_RX_B: if (wRxValid) begin
                    rTout    <= '0;
                    rByteCnt <= rByteCnt + 1'b1;
                    if (rState == S_RX_A) rA <= {rA[OPERAND_WIDTH-9:0], wRxData};
                    else                  rB <= {rB[OPERAND_WIDTH-9:0], wRxData};
                    if (rByteCnt == c_lastByte) begin
                        rByteCnt <= '0;
                        if (rState == S_RX_A) rState <= S_RX_B;
                        else begin
                            rState <= S_COMPUTE;
                            rChunk <= '0;
                            rCarry <= rSub;
                        end
                    end
                end else if (rTout == c_timeout) begin
                    rFrameErr <= 1'b1;
                    rBusy     <= 1'b0;
                    rState    <= S_IDLE;
                end else rTout <= rTout + 1'b1;
                S_COMPUTE: begin
                    rA     <= {wSum[ADDER_WIDTH-1:0], rA[OPERAND_WIDTH-1:ADDER_WIDTH]};
                    rB     <= rB >> ADDER_WIDTH;
                    rCarry <= wSum[ADDER_WIDTH];
                    rChunk <= rChunk + 1'b1;
                    if (rChunk == c_lastChunk) begin
                        rHead   <= {7'b0, rSub ? ~wSum[ADDER_WIDTH] : wSum[ADDER_WIDTH]};
                        rTxCnt  <= '0;
                        rTxLast <= c_txLastFull;
                        rChk    <= '0;
                        rState  <= S_TX;
                    end
                end
                S_TX: if (!wTxBusy) begin
                    rTxStart <= 1'b1;
                    rTxData  <= wTxByte;
                    rChk     <= rChk ^ wTxByte;
                    if (rTxCnt != '0) rA <= rA << 8;
                    rState   <= S_TX_WAIT;
                end
                S_TX_WAIT: if (wTxDone) begin
                    if (rTxCnt == rTxLast) begin
                        rBusy  <= 1'b0;
                        rState <= S_IDLE;
                    end else begin
                        rTxCnt <= rTxCnt + 1'b1;
                        rState <= S_TX;
                    end
                end
                default: rState <= S_IDLE;
            endcase
        end
    end

    assign oBusy     = rBusy;
    assign oFrameErr = rFrameErr;
endmodule

`default_nettype wire

// File: tb/tb_uart_alu_top.sv
// ============================================================================
//  Module      : tb_uart_alu_top
//  Description : Self-checking bench for uart_alu_top (32-bit operands, 8-bit chunks).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_alu_top;
    localparam int OW = 32, AW = 8, CLKF = 8, BAUD = 1, TOC = 200;
    localparam int BITC = CLKF / BAUD;

    logic iClk = 1'b0, iRst = 1'b1, iRx = 1'b1;
    logic oTx, oBusy, oFrameErr;

    always #5 iClk = ~iClk;

    uart_alu_top #(.OPERAND_WIDTH(OW), .ADDER_WIDTH(AW), .CLK_FREQ(CLKF),
                   .BAUD_RATE(BAUD), .TIMEOUT_CYCLES(TOC)) dut (
        .iClk(iClk), .iRst(iRst), .iRx(iRx), .oTx(oTx), .oBusy(oBusy), .oFrameErr(oFrameErr));

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [7:0]  flag;
        logic [31:0] res;
    } vec_t;

    vec_t       tbl[8];
    int         checks = 0, errors = 0, errPulses = 0;
    logic [7:0] rxq[$];
    logic [7:0] expQ[$];
    logic [7:0] mb;

    // Serial receiver on oTx: samples each bit near its centre.
    initial forever begin
        @(negedge iClk);
        if (oTx === 1'b0) begin
            repeat (BITC / 2) @(negedge iClk);
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(negedge iClk);
                mb[i] = oTx;
            end
            repeat (BITC) @(negedge iClk);
            rxq.push_back(mb);
        end
    end

    always @(negedge iClk) if (oFrameErr === 1'b1) errPulses++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge iClk); iRx = 1'b0;
        repeat (BITC) @(negedge iClk);
        for (int i = 0; i < 8; i++) begin
            iRx = b[i];
            repeat (BITC) @(negedge iClk);
        end
        iRx = 1'b1;
        repeat (BITC) @(negedge iClk);
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        sendByte(op);
        for (int i = 3; i >= 0; i--) sendByte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) sendByte(b[8*i +: 8]);
    endtask

    function automatic void addChecksum();
`ifdef UART_ALU_CHKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (expQ[i]) x ^= expQ[i];
        expQ.push_back(x);
`endif
    endfunction

    function automatic void setExpected(input logic [7:0] flag, input logic [31:0] res);
        expQ.delete();
        expQ.push_back(flag);
        for (int i = 3; i >= 0; i--) expQ.push_back(res[8*i +: 8]);
        addChecksum();
    endfunction

    // Reference: whole-word arithmetic on the frame contents.
    function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        if (op == 8'h01) begin
            s = {1'b0, a} + {1'b0, b};
            setExpected({7'b0, s[32]}, s[31:0]);
        end else if (op == 8'h02) begin
            setExpected({7'b0, (a < b)}, a - b);
        end else begin
            expQ.delete();
            expQ.push_back(8'hEE);
            addChecksum();
        end
    endfunction

    task automatic checkResp(input string name);
        for (int c = 0; c < 4000 && rxq.size() < expQ.size(); c++) @(negedge iClk);
        repeat (BITC * 14) @(negedge iClk);
        chk({name, "_len"}, 64'(rxq.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++)
            chk({name, "_byte"}, (i < rxq.size()) ? {56'd0, rxq[i]} : 64'hDEAD, {56'd0, expQ[i]});
        chk({name, "_busy_low"}, {63'd0, oBusy}, 64'd0);
        rxq.delete();
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b;
        int          p0;

        tbl[0] = '{8'h01, 32'hFFFFFFFF, 32'h00000001, 8'h01, 32'h00000000};
        tbl[1] = '{8'h02, 32'h00000001, 32'h00000002, 8'h01, 32'hFFFFFFFF};
        tbl[2] = '{8'h02, 32'h00000005, 32'h00000003, 8'h00, 32'h00000002};
        tbl[3] = '{8'h01, 32'h12345678, 32'h11111111, 8'h00, 32'h23456789};
        tbl[4] = '{8'h02, 32'h00000000, 32'h00000000, 8'h00, 32'h00000000};
        tbl[5] = '{8'h01, 32'h80000000, 32'h80000000, 8'h01, 32'h00000000};
        tbl[6] = '{8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 32'h00000000};
        tbl[7] = '{8'h02, 32'h00000000, 32'h00000001, 8'h01, 32'hFFFFFFFF};

        repeat (5) @(negedge iClk);
        chk("reset_tx", {63'd0, oTx}, 64'd1);
        chk("reset_busy", {63'd0, oBusy}, 64'd0);
        chk("reset_ferr", {63'd0, oFrameErr}, 64'd0);
        iRst = 1'b0;
        repeat (5) @(negedge iClk);

        for (int i = 0; i < 8; i++) begin
            setExpected(tbl[i].flag, tbl[i].res);
            sendFrame(tbl[i].op, tbl[i].a, tbl[i].b);
            chk("tbl_busy_high", {63'd0, oBusy}, 64'd1);
            checkResp("tbl");
        end

        for (int i = 0; i < 6; i++) begin
            op = 8'($urandom_range(1, 2));
            a  = $urandom;
            b  = (i == 5) ? a : $urandom;
            model(op, a, b);
            sendFrame(op, a, b);
            checkResp("rand");
        end

        p0 = errPulses;
        model(8'h7F, 32'h0, 32'h0);
        sendByte(8'h7F);
        checkResp("badop");
        chk("badop_pulse", 64'(errPulses - p0), 64'd1);
        model(8'h01, 32'hA5A5A5A5, 32'h5A5A5A5B);
        sendFrame(8'h01, 32'hA5A5A5A5, 32'h5A5A5A5B);
        checkResp("after_badop");

        p0 = errPulses;
        sendByte(8'h01); sendByte(8'hAA); sendByte(8'hBB);
        repeat (3 * TOC) @(negedge iClk);
        chk("tout_pulse", 64'(errPulses - p0), 64'd1);
        chk("tout_no_tx", 64'(rxq.size()), 64'd0);
        chk("tout_busy", {63'd0, oBusy}, 64'd0);
        model(8'h02, 32'h00001000, 32'h00000FFF);
        sendFrame(8'h02, 32'h00001000, 32'h00000FFF);
        checkResp("after_tout");

        sendFrame(8'h01, 32'hFFFFFFFF, 32'h00000001);
        for (int c = 0; c < 4000 && rxq.size() < 2; c++) @(negedge iClk);
        chk("midtx_started", 64'(rxq.size() >= 2), 64'd1);
        repeat (BITC * 3) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        chk("midtx_rst_tx", {63'd0, oTx}, 64'd1);
        chk("midtx_rst_busy", {63'd0, oBusy}, 64'd0);
        iRst = 1'b0;
        repeat (BITC * 14) @(negedge iClk);
        rxq.delete();
        model(8'h01, 32'h0000FFFF, 32'h00010001);
        sendFrame(8'h01, 32'h0000FFFF, 32'h00010001);
        checkResp("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
